// File: rtl/data_mem_ctrl_if.sv
// Load/store bus between the MEM stage and the data memory controller.
// Request fields flow master->slave; handshake and response flow back.
interface data_mem_ctrl_if;
   logic        req;
   logic        we;
   logic [2:0]  access;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;
   logic        fault;
   logic        busy;

   modport master (
      output req, we, access, addr, wdata,
      input  ready, rvalid, rdata, fault, busy
   );

   modport slave (
      input  req, we, access, addr, wdata,
      output ready, rvalid, rdata, fault, busy
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised RV32 data memory with req/ready/rvalid handshake,
// lane placement, access faults and a post-reset clear sweep.
module data_mem_ctrl #(
   parameter int ADDR_WIDTH     = 12,
   parameter int LATENCY        = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input logic           clk,
   input logic           rstn,
   data_mem_ctrl_if.slave bus
);

   localparam int IW    = ADDR_WIDTH - 2;
   localparam int DEPTH = 1 << IW;
   localparam logic [1:0] CNT0 = 2'(LATENCY - 1);
   localparam logic       LAST = (LATENCY == 1);

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      WAIT
   } state_t;

   state_t          state;
   logic [1:0]      cnt;
   logic [IW-1:0]   clr_idx;
   logic            ready;
   logic            rvalid;
   logic            busy;

   logic [31:0]     mem [DEPTH];
   logic [31:0]     d_pipe [LATENCY];
   logic [LATENCY-1:0] f_pipe;

   logic            accept;
   logic [IW-1:0]   idx;
   logic            is_b;
   logic            is_h;
   logic            sx;
   logic            bad;
   logic            wr_en;
   logic [3:0]      be;
   logic [31:0]     wd;
   logic [31:0]     word;
   logic [31:0]     shifted;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;
   logic [31:0]     ld;
   logic [31:0]     res;
   logic            unused_addr;

   assign accept = bus.req & ready;
   assign idx    = bus.addr[ADDR_WIDTH-1:2];
   assign is_b   = (bus.access[1:0] == 2'b00);
   assign is_h   = (bus.access[1:0] == 2'b01);
   assign sx     = ~bus.access[2];
   assign wr_en  = accept & bus.we & ~bad;

   // Upper address bits alias the array
   assign unused_addr = ^bus.addr[31:ADDR_WIDTH];

   always_comb begin
      bad = 1'b0;
      unique case (bus.access)
         3'b000:  bad = 1'b0;
         3'b001:  bad = bus.addr[0];
         3'b010:  bad = |bus.addr[1:0];
         3'b100:  bad = bus.we;
         3'b101:  bad = bus.we | bus.addr[0];
         default: bad = 1'b1;
      endcase
   end

   always_comb begin
      be = 4'hF;
      wd = bus.wdata;
      unique case (1'b1)
         is_b: begin
            be = 4'b0001 << bus.addr[1:0];
            wd = {4{bus.wdata[7:0]}};
         end
         is_h: begin
            be = bus.addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{bus.wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign word    = mem[idx];
   assign shifted = word >> {bus.addr[1:0], 3'b000};
   assign byte_v  = shifted[7:0];
   assign half_v  = bus.addr[1] ? word[31:16] : word[15:0];

   always_comb begin
      ld = word;
      unique case (1'b1)
         is_b:    ld = {{24{sx & byte_v[7]}}, byte_v};
         is_h:    ld = {{16{sx & half_v[15]}}, half_v};
         default: ld = word;
      endcase
   end

   assign res = (bad | bus.we) ? 32'h0 : ld;

   // Array has no reset so contents survive when the sweep is disabled
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_idx] <= 32'h0;
      end else if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
         busy    <= CLEAR_ON_RESET;
         ready   <= 1'b0;
         rvalid  <= 1'b0;
         cnt     <= 2'd0;
         clr_idx <= '0;
      end else begin
         unique case (state)
            CLEAR: begin
               clr_idx <= clr_idx + IW'(1);
               if (clr_idx == IW'(DEPTH - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  ready <= 1'b1;
               end
            end
            IDLE: begin
               ready <= 1'b1;
               if (accept) begin
                  state  <= WAIT;
                  cnt    <= CNT0;
                  rvalid <= LAST;
                  ready  <= LAST;
               end
            end
            WAIT: begin
               if (cnt != 2'd0) begin
                  cnt    <= cnt - 2'd1;
                  rvalid <= (cnt == 2'd1);
                  ready  <= (cnt == 2'd1);
               end else if (accept) begin
                  cnt    <= CNT0;
                  rvalid <= LAST;
                  ready  <= LAST;
               end else begin
                  state  <= IDLE;
                  rvalid <= 1'b0;
                  ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result shift line: only the accepted slot is non-zero
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < LATENCY; i++) d_pipe[i] <= 32'h0;
         f_pipe <= '0;
      end else begin
         d_pipe[0] <= accept ? res : 32'h0;
         f_pipe[0] <= accept & bad;
         for (int i = 1; i < LATENCY; i++) begin
            d_pipe[i] <= d_pipe[i-1];
            f_pipe[i] <= f_pipe[i-1];
         end
      end
   end

   assign bus.ready  = ready;
   assign bus.rvalid = rvalid;
   assign bus.busy   = busy;
   assign bus.rdata  = d_pipe[LATENCY-1];
   assign bus.fault  = f_pipe[LATENCY-1];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: default, LATENCY=3 and
// no-clear instances driven from one stimulus thread.
module tb_data_mem_ctrl;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   logic        clk;
   logic [2:0]  rstn;
   logic [2:0]  req;
   logic [2:0]  we;
   logic [2:0]  acc  [3];
   logic [31:0] adr  [3];
   logic [31:0] wdat [3];
   logic [2:0]  rdy;
   logic [2:0]  rvld;
   logic [2:0]  flt;
   logic [2:0]  bsy;
   logic [31:0] rdat [3];

   int n_chk  = 0;
   int n_pass = 0;

   data_mem_ctrl_if ia ();
   data_mem_ctrl_if ib ();
   data_mem_ctrl_if ic ();

   assign ia.req = req[0];  assign ia.we = we[0];
   assign ia.access = acc[0];
   assign ia.addr = adr[0]; assign ia.wdata = wdat[0];
   assign rdy[0] = ia.ready;  assign rvld[0] = ia.rvalid;
   assign flt[0] = ia.fault;  assign bsy[0] = ia.busy;
   assign rdat[0] = ia.rdata;

   assign ib.req = req[1];  assign ib.we = we[1];
   assign ib.access = acc[1];
   assign ib.addr = adr[1]; assign ib.wdata = wdat[1];
   assign rdy[1] = ib.ready;  assign rvld[1] = ib.rvalid;
   assign flt[1] = ib.fault;  assign bsy[1] = ib.busy;
   assign rdat[1] = ib.rdata;

   assign ic.req = req[2];  assign ic.we = we[2];
   assign ic.access = acc[2];
   assign ic.addr = adr[2]; assign ic.wdata = wdat[2];
   assign rdy[2] = ic.ready;  assign rvld[2] = ic.rvalid;
   assign flt[2] = ic.fault;  assign bsy[2] = ic.busy;
   assign rdat[2] = ic.rdata;

   data_mem_ctrl u_a (
      .clk  (clk),
      .rstn (rstn[0]),
      .bus  (ia.slave)
   );

   data_mem_ctrl #(.LATENCY(3)) u_b (
      .clk  (clk),
      .rstn (rstn[1]),
      .bus  (ib.slave)
   );

   data_mem_ctrl #(.CLEAR_ON_RESET(1'b0)) u_c (
      .clk  (clk),
      .rstn (rstn[2]),
      .bus  (ic.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic [2:0]  a;
      logic [31:0] ad;
      logic [31:0] wd;
      logic [31:0] er;
      logic        ef;
      string       nm;
   } vec_t;

   vec_t tv [$];

   task automatic add(input logic w, input logic [2:0] a,
                      input logic [31:0] ad, input logic [31:0] wd,
                      input logic [31:0] er, input logic ef,
                      input string nm);
      vec_t v;
      v.w = w; v.a = a; v.ad = ad; v.wd = wd;
      v.er = er; v.ef = ef; v.nm = nm;
      tv.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic op(input int d, input logic w, input logic [2:0] a,
                     input logic [31:0] ad, input logic [31:0] wd,
                     output logic [31:0] rd, output logic f,
                     output int lat);
      int g = 0;
      @(negedge clk);
      while (!rdy[d] && g < 3000) begin
         @(negedge clk);
         g++;
      end
      chk("ready_wait", {31'b0, rdy[d]}, 1);
      req[d] = 1'b1; we[d] = w; acc[d] = a;
      adr[d] = ad; wdat[d] = wd;
      @(posedge clk);
      #1 req[d] = 1'b0;
      lat = 1;
      while (!rvld[d] && lat < 8) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("rvalid_seen", {31'b0, rvld[d]}, 1);
      rd = rdat[d];
      f = flt[d];
      @(posedge clk);
      #1 chk("rvalid_pulse", {31'b0, rvld[d]}, 0);
   endtask

   task automatic sweep(input int d, input string nm, input int start);
      int   n = start;
      logic bad = 1'b0;
      while (bsy[d] && n < 3000) begin
         @(posedge clk);
         #1 n++;
         if (bsy[d] && (rdy[d] || rvld[d])) bad = 1'b1;
      end
      chk(nm, n, 1024);
      chk({nm, "_quiet"}, {31'b0, bad}, 0);
   endtask

   logic [31:0] rd;
   logic        f;
   int          lat;
   logic [2:0]  hacc [4];
   logic [31:0] hadr [4];
   logic [31:0] hexp [4];
   logic        seen;

   initial begin
      rstn = 3'b000; req = 3'b000; we = 3'b000;
      for (int i = 0; i < 3; i++) begin
         acc[i] = 3'b0; adr[i] = 32'h0; wdat[i] = 32'h0;
      end

      add(0, LW,  32'h000, 0, 32'h00000000, 0, "lw_000");
      add(0, LW,  32'h7FC, 0, 32'h00000000, 0, "lw_7fc");
      add(0, LW,  32'hFFC, 0, 32'h00000000, 0, "lw_ffc");
      add(1, LW,  32'h100, 32'h80F1E2D3, 0, 0, "sw_100");
      add(0, LW,  32'h100, 0, 32'h80F1E2D3, 0, "lw_100");
      add(0, LB,  32'h103, 0, 32'hFFFFFF80, 0, "lb_103");
      add(0, LBU, 32'h103, 0, 32'h00000080, 0, "lbu_103");
      add(0, LH,  32'h102, 0, 32'hFFFF80F1, 0, "lh_102");
      add(0, LHU, 32'h100, 0, 32'h0000E2D3, 0, "lhu_100");
      add(1, LB,  32'h101, 32'hFFFFFF5A, 0, 0, "sb_101");
      add(0, LW,  32'h100, 0, 32'h80F15AD3, 0, "lw_after_sb");
      add(1, LH,  32'h102, 32'hABCD1234, 0, 0, "sh_102");
      add(0, LW,  32'h100, 0, 32'h12345AD3, 0, "lw_after_sh");
      add(0, LW,  32'h102, 0, 32'h0, 1, "lw_misalign");
      add(1, LH,  32'h101, 32'h0000FFFF, 0, 1, "sh_misalign");
      add(0, 3'b011, 32'h100, 0, 32'h0, 1, "acc_011");
      add(1, LBU, 32'h100, 32'h000000FF, 0, 1, "st_bu");
      add(1, LW,  32'h101, 32'hDEADBEEF, 0, 1, "sw_misalign");
      add(1, 3'b110, 32'h100, 32'h0, 0, 1, "st_110");
      add(0, LW,  32'h100, 0, 32'h12345AD3, 0, "lw_unchanged");
      add(0, LW,  32'h1100, 0, 32'h12345AD3, 0, "lw_alias");
      add(0, LB,  32'h100, 0, 32'hFFFFFFD3, 0, "lb_100");
      add(0, LH,  32'h100, 0, 32'h00005AD3, 0, "lh_100");
      add(0, LHU, 32'h102, 0, 32'h00001234, 0, "lhu_102");
      add(1, LB,  32'hFFF, 32'h0000007F, 0, 0, "sb_fff");
      add(0, LB,  32'hFFF, 0, 32'h0000007F, 0, "lb_fff");
      add(0, LBU, 32'hFFC, 0, 32'h00000000, 0, "lbu_ffc");

      repeat (3) @(negedge clk);
      chk("rst_rvalid", {31'b0, rvld[0]}, 0);
      chk("rst_ready",  {31'b0, rdy[0]}, 0);
      chk("rst_busy",   {31'b0, bsy[0]}, 1);
      chk("rst_rdata",  rdat[0], 0);
      chk("rst_fault",  {31'b0, flt[0]}, 0);
      chk("rst_busy_c", {31'b0, bsy[2]}, 0);
      chk("rst_rdy_c",  {31'b0, rdy[2]}, 0);
      rstn = 3'b111;
      @(posedge clk);
      #1 chk("c_ready_first", {31'b0, rdy[2]}, 1);
      sweep(0, "a_sweep", 1);

      foreach (tv[i]) begin
         op(0, tv[i].w, tv[i].a, tv[i].ad, tv[i].wd, rd, f, lat);
         chk({tv[i].nm, "_data"}, rd, tv[i].er);
         chk({tv[i].nm, "_fault"}, {31'b0, f}, {31'b0, tv[i].ef});
         chk({tv[i].nm, "_lat"}, lat, 1);
      end

      op(1, 1'b1, LW, 32'h0, 32'h11223344, rd, f, lat);
      chk("b_store_lat", lat, 3);
      hacc = '{LW, LBU, LH, LB};
      hadr = '{32'h0, 32'h1, 32'h2, 32'h0};
      hexp = '{32'h11223344, 32'h00000033, 32'h00001122, 32'h00000044};
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b0;
      acc[1] = hacc[0]; adr[1] = hadr[0];
      @(posedge clk);
      for (int k = 1; k <= 12; k++) begin
         #1;
         chk("b_hold_rvalid", {31'b0, rvld[1]}, {31'b0, (k % 3 == 0)});
         chk("b_hold_ready", {31'b0, rdy[1]}, {31'b0, (k % 3 == 0)});
         if (k % 3 == 0) begin
            chk("b_hold_data", rdat[1], hexp[k/3-1]);
            if (k < 12) begin
               acc[1] = hacc[k/3]; adr[1] = hadr[k/3];
            end else begin
               req[1] = 1'b0;
            end
         end
         @(posedge clk);
      end

      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b0; acc[1] = LW; adr[1] = 32'h0;
      @(posedge clk);
      #1 req[1] = 1'b0;
      @(negedge clk);
      rstn[1] = 1'b0;
      #1 chk("b_rst_busy", {31'b0, bsy[1]}, 1);
      chk("b_rst_rvalid", {31'b0, rvld[1]}, 0);
      @(negedge clk);
      rstn[1] = 1'b1;
      sweep(1, "b_sweep_wait", 0);

      op(1, 1'b1, LW, 32'h40, 32'hA5A5A5A5, rd, f, lat);
      @(negedge clk);
      rstn[1] = 1'b0;
      @(negedge clk);
      rstn[1] = 1'b1;
      seen = 1'b0;
      repeat (500) begin
         @(posedge clk);
         #1 if (rvld[1] || !bsy[1]) seen = 1'b1;
      end
      chk("b_partial_busy", {31'b0, seen}, 0);
      @(negedge clk);
      rstn[1] = 1'b0;
      @(negedge clk);
      rstn[1] = 1'b1;
      sweep(1, "b_sweep_clr", 0);
      op(1, 1'b0, LW, 32'h0, 32'h0, rd, f, lat);
      chk("b_cleared_0", rd, 0);
      op(1, 1'b0, LW, 32'h40, 32'h0, rd, f, lat);
      chk("b_cleared_40", rd, 0);

      op(2, 1'b1, LW, 32'h20, 32'hCAFEF00D, rd, f, lat);
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; acc[2] = LW;
      adr[2] = 32'h24; wdat[2] = 32'h0BADBEEF;
      @(posedge clk);
      #1 req[2] = 1'b0;
      rstn[2] = 1'b0;
      #1 chk("c_rst_rvalid", {31'b0, rvld[2]}, 0);
      chk("c_rst_busy", {31'b0, bsy[2]}, 0);
      @(negedge clk);
      rstn[2] = 1'b1;
      @(posedge clk);
      #1 chk("c_ready_after", {31'b0, rdy[2]}, 1);
      op(2, 1'b0, LW, 32'h20, 32'h0, rd, f, lat);
      chk("c_keep_20", rd, 32'hCAFEF00D);
      op(2, 1'b0, LW, 32'h24, 32'h0, rd, f, lat);
      chk("c_keep_24", rd, 32'h0BADBEEF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
